sha3_32_host: RTL
=================

Name: sha3_32_host

Overview:
- Command-driven initiator that drives the 32-bit SHA3/SHAKE core's word-write/start/read interface.
- Accepts a message as a 32-bit little-endian word stream and applies the FIPS 202 padding.
- Writes each full rate block into the core, runs absorb permutations, then squeezes a requested number of 32-bit output words onto a valid/ready stream.
- Sits between the signing datapath (seed expansion, message hashing) and the core.

Parameters:
- OUTW_W, 16, width of the output-word count.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_mode  in  3  SHAmode encoding (codebase SHAMODE_* constants)
- cmd_out_words  in  OUTW_W  number of output words; 0 is treated as 1
- in_valid  in  1  message word valid
- in_ready  out  1  message word accepted
- in_data  in  32  message bytes, byte 0 in bits [7:0]
- in_last  in  1  final message word
- in_bytes  in  3  valid bytes in the last word, 0..4; 0 is legal only with in_last (empty tail); ignored when in_last=0
- out_valid  out  1  digest word valid
- out_ready  in  1  digest word accepted
- out_data  out  32  digest word
- out_last  out  1  final digest word
- busy  out  1  high when not in IDLE
- core_rst_n  out  1  core reset, active low
- core_shamode  out  3  latched cmd_mode
- core_asmode  out  1  ASMODE_ABSORB or ASMODE_SQUEEZE
- core_start  out  1  permutation start pulse
- core_ready  in  1  core ready
- core_we  out  1  core word write
- core_address  out  6  core word index
- core_data_in  out  32  core write data
- core_data_out  in  32  core combinational read data

Behaviour:
- Reset values: cmd_ready=1, busy=0, in_ready=0, out_valid=0, out_last=0, core_we=0, core_start=0, core_rst_n=0, core_asmode=ABSORB, core_address=0. The FSM returns to IDLE from any state; a reset mid-operation discards the command.
- Rate R in words: SHAKE128=42, SHA3-224=36, SHA3-256=34, SHAKE256=34, SHA3-384=26, SHA3-512=18.
- Domain suffix: 0x1F for SHAKE modes, 0x06 for SHA3 modes.
- IDLE: core_rst_n=1. When cmd_valid is high, latch the mode, out_words and R, then go to CRST.
- CRST: core_rst_n=0 for exactly 1 cycle; this clears the core state. Then go to ABSORB with widx=0 and pend=0.
- ABSORB: core_asmode=ABSORB. in_ready=1 unless pend=1 or the tail has been consumed. Each accepted word produces core_we=1, core_address=widx, and core_data_in equal to the padded word, in the same cycle.
  - Non-last word: written unchanged.
  - Last word with k<4 bytes: bytes k..3 are zeroed; the suffix goes in byte k.
  - Last word with k=4: written unchanged; set pend=1.
- Pad words: after the tail, every remaining widx<R is written autonomously at one word per cycle. Each pad word is 0, except that the suffix is placed in byte 0 when pend=1 (pend then clears).
- Final pad bit: the word at widx=R-1 of the final block gets bit 31 ORed in. If the suffix also lands there, the byte is 0x9F for SHAKE or 0x86 for SHA3.
- Block boundary: after the write at widx=R-1, go to PSTART.
  - If the tail is unfinished, or pend=1, a further block follows (widx wraps to 0). This covers a message that exactly fills a block: it gets one extra block holding the suffix and the final bit.
  - Every block writes all R words, because the core does not clear its rate register.
- PSTART: core_start=1 for 1 cycle. The core's ready goes low on the next cycle. No core_we may occur until core_ready is high again.
- PWAIT: skip 1 guard cycle, then wait for core_ready. Latency is 25 cycles from start to ready.
  - Next state is ABSORB if further blocks remain.
  - Otherwise set core_asmode=SQUEEZE and sidx=0, then go to SQREAD.
- SQREAD: core_address=sidx, out_data=core_data_out, out_valid=1. out_data must stay stable while out_ready=0.
  - On each handshake, increment sidx and the sent count.
  - out_last=1 when sent==out_words-1; after that handshake go to IDLE.
  - When sidx reaches R with words still pending, go to SQSTART.
- SQSTART / SQWAIT: same as PSTART/PWAIT with core_asmode=SQUEEZE. Then sidx=0 and return to SQREAD.
- cmd_valid is ignored while busy. in_ready=0 outside ABSORB.

Test Plan:
- SHAKE256, empty message (one word, in_last=1, in_bytes=0), out_words=2 -> out_data 0x2bddb946 then a second word; out_last on the 2nd word; exactly one absorb start.
- SHA3-256, "abc" (in_data=0x00636261, in_bytes=3), out_words=8 -> word0=0xa75d983a; word written at address 0 is 0x06636261; word at address 33 is 0x80000000.
- SHAKE256, 34 full words, last with in_bytes=4 -> two absorb starts; second block writes address 0=0x0000001F, address 33=0x80000000, all others 0.
- SHAKE128, empty message, out_words=50 -> word0=0xa42b9c7f; exactly one squeeze start, issued after 42 words; 50 handshakes; out_last on the 50th.
- Random out_ready backpressure plus stalls between in_valid words -> digest identical to the no-stall run; out_data stable across stalls.
- Back-to-back commands (SHAKE256 "abc" twice), plus rst asserted mid-PWAIT -> core_rst_n pulses before each hash; both digests give word0=0x60663348; after the mid-PWAIT reset, cmd_ready=1 and the next hash is correct.

Source files
------------

// File: rtl/sha3_32_host.sv
// sha3_32_host
// Command-driven initiator for the 32-bit SHA3/SHAKE core. It accepts a
// message as a little-endian 32-bit word stream and applies the FIPS 202
// padding on the fly. Every rate block is written into the core and
// absorbed. The requested number of output words is then squeezed out on a
// valid/ready stream.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   cmd_*           command handshake: SHA mode and output word count
//                   (a count of 0 is treated as 1)
//   in_*            message words: valid/ready, last flag and byte count
//                   of the last word (0..4)
//   out_*           digest words: valid/ready, last flag
//   busy            high whenever the host is not idle
//   core_*          word-write / start / read interface of the SHA3 core
module sha3_32_host #(
  parameter int OUTW_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_mode,
  input  logic [OUTW_W-1:0] cmd_out_words,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  input  logic [2:0]        in_bytes,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              out_last,
  output logic              busy,
  output logic              core_rst_n,
  output logic [2:0]        core_shamode,
  output logic              core_asmode,
  output logic              core_start,
  input  logic              core_ready,
  output logic              core_we,
  output logic [5:0]        core_address,
  output logic [31:0]       core_data_in,
  input  logic [31:0]       core_data_out
);

  localparam logic [2:0] SHAMODE_SHA3_224 = 3'd0;
  localparam logic [2:0] SHAMODE_SHA3_256 = 3'd1;
  localparam logic [2:0] SHAMODE_SHA3_384 = 3'd2;
  localparam logic [2:0] SHAMODE_SHA3_512 = 3'd3;
  localparam logic [2:0] SHAMODE_SHAKE128 = 3'd4;
  localparam logic [2:0] SHAMODE_SHAKE256 = 3'd5;
  localparam logic       ASMODE_ABSORB    = 1'b0;
  localparam logic       ASMODE_SQUEEZE   = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE, S_CRST, S_ABSORB, S_PSTART, S_PWAIT, S_SQREAD, S_SQSTART, S_SQWAIT
  } state_t;

  state_t            state, state_next;
  logic [2:0]        mode;
  logic [5:0]        rate;
  logic [OUTW_W-1:0] last_idx, sent;
  logic [5:0]        widx, sidx;
  logic              pend, tail_done, more_blocks, guard, asmode;

  logic [7:0]        suffix;
  logic              full_tail;
  logic [31:0]       tail_word;
  logic              take_word, pad_write, final_block, block_end;

  function automatic logic [5:0] rate_of(input logic [2:0] m);
    case (m)
      SHAMODE_SHAKE128: rate_of = 6'd42;
      SHAMODE_SHA3_224: rate_of = 6'd36;
      SHAMODE_SHA3_256: rate_of = 6'd34;
      SHAMODE_SHAKE256: rate_of = 6'd34;
      SHAMODE_SHA3_384: rate_of = 6'd26;
      SHAMODE_SHA3_512: rate_of = 6'd18;
      default:          rate_of = 6'd34;
    endcase
  endfunction

  assign suffix       = (mode == SHAMODE_SHAKE128 || mode == SHAMODE_SHAKE256) ? 8'h1F : 8'h06;
  // Byte counts above 4 behave as a full word.
  assign full_tail    = (in_bytes >= 3'd4);
  // The core is held in reset during rst as well as for the CRST cycle.
  assign core_rst_n   = !(rst || state == S_CRST);
  assign core_shamode = mode;
  assign core_asmode  = asmode;
  assign busy         = (state != S_IDLE);

  // Last message word with k<4 bytes: bytes above k are zeroed and the
  // domain suffix goes into byte k.
  always_comb begin
    tail_word = in_data;
    if (in_last && !full_tail) begin
      for (int b = 0; b < 4; b++) begin
        if (3'(b) == in_bytes) tail_word[8*b +: 8] = suffix;
        else if (3'(b) > in_bytes) tail_word[8*b +: 8] = 8'h00;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // final_block marks a write that belongs to the last block. Pad words
  // always do. An input word does only if it is the tail and its suffix
  // fits; a full 4-byte tail pushes the suffix into the next word.
  always_comb begin
    state_next   = state;
    cmd_ready    = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    out_data     = 32'h0;
    core_start   = 1'b0;
    core_we      = 1'b0;
    core_address = 6'd0;
    core_data_in = 32'h0;
    take_word    = 1'b0;
    pad_write    = 1'b0;
    final_block  = 1'b0;
    block_end    = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = S_CRST;
      end
      S_CRST: state_next = S_ABSORB;
      S_ABSORB: begin
        in_ready     = !pend && !tail_done;
        core_address = widx;
        if (in_ready && in_valid) begin
          take_word    = 1'b1;
          core_we      = 1'b1;
          core_data_in = tail_word;
          final_block  = in_last && !full_tail;
        end else if (tail_done) begin
          pad_write    = 1'b1;
          core_we      = 1'b1;
          core_data_in = {24'h0, pend ? suffix : 8'h00};
          final_block  = 1'b1;
        end
        block_end = core_we && (widx == rate - 6'd1);
        if (block_end) begin
          if (final_block) core_data_in[31] = 1'b1;
          state_next = S_PSTART;
        end
      end
      S_PSTART: begin
        core_start = 1'b1;
        state_next = S_PWAIT;
      end
      S_PWAIT: begin
        if (!guard && core_ready) state_next = more_blocks ? S_ABSORB : S_SQREAD;
      end
      S_SQREAD: begin
        out_valid    = 1'b1;
        out_last     = (sent == last_idx);
        core_address = sidx;
        out_data     = core_data_out;
        if (out_ready) begin
          if (out_last) state_next = S_IDLE;
          else if (sidx == rate - 6'd1) state_next = S_SQSTART;
        end
      end
      S_SQSTART: begin
        core_start = 1'b1;
        state_next = S_SQWAIT;
      end
      S_SQWAIT: begin
        if (!guard && core_ready) state_next = S_SQREAD;
      end
    endcase
  end

  // Datapath registers: command latch, word indices, tail/pad tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode        <= SHAMODE_SHAKE256;
      rate        <= 6'd34;
      last_idx    <= '0;
      sent        <= '0;
      widx        <= 6'd0;
      sidx        <= 6'd0;
      pend        <= 1'b0;
      tail_done   <= 1'b0;
      more_blocks <= 1'b0;
      guard       <= 1'b0;
      asmode      <= ASMODE_ABSORB;
    end else begin
      case (state)
        S_IDLE: begin
          asmode <= ASMODE_ABSORB;
          if (cmd_valid) begin
            mode     <= cmd_mode;
            rate     <= rate_of(cmd_mode);
            last_idx <= (cmd_out_words == '0) ? '0 : cmd_out_words - OUTW_W'(1);
          end
        end
        S_CRST: begin
          widx      <= 6'd0;
          pend      <= 1'b0;
          tail_done <= 1'b0;
          sent      <= '0;
        end
        S_ABSORB: begin
          if (core_we) widx <= block_end ? 6'd0 : widx + 6'd1;
          if (block_end) more_blocks <= !final_block;
          if (take_word && in_last) begin
            tail_done <= 1'b1;
            pend      <= full_tail;
          end else if (pad_write) begin
            pend <= 1'b0;
          end
        end
        S_PSTART, S_SQSTART: guard <= 1'b1;
        S_PWAIT: begin
          if (guard) guard <= 1'b0;
          else if (core_ready && !more_blocks) begin
            asmode <= ASMODE_SQUEEZE;
            sidx   <= 6'd0;
          end
        end
        S_SQREAD: begin
          if (out_ready) begin
            sent <= sent + OUTW_W'(1);
            sidx <= sidx + 6'd1;
          end
        end
        S_SQWAIT: begin
          if (guard) guard <= 1'b0;
          else if (core_ready) sidx <= 6'd0;
        end
        default: ;
      endcase
    end
  end

endmodule
